// File: rtl/tx_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_controller
//  Description : Snapshots an ALU result and its flags on a display command,
//                then streams a framed byte sequence to uart_tx:
//                HEADER_BYTE, result bytes LSB first, flags byte
//                (plus an XOR checksum byte when TX_FRAME_CHECKSUM_EN is
//                defined). Each byte is confirmed by a full busy handshake:
//                busy must rise and then fall again. One further command can
//                be held pending while a frame is in flight.
//  Config      : `define TX_FRAME_CHECKSUM_EN to append the checksum byte.
//  Ports       :
//    clk               in   system clock, rising edge
//    reset_n           in   asynchronous active-low reset
//    display_cmd_pulse in   1-cycle request to send one frame
//    alu_result        in   DATA_WIDTH result, sampled in S_LOAD only
//    alu_flags         in   FLAG_WIDTH flags, sampled in S_LOAD only
//    tx_busy           in   uart_tx busy flag
//    tx_data_out       out  byte for uart_tx, valid with tx_start_pulse
//    tx_start_pulse    out  1-cycle start strobe
//    frame_busy        out  high from S_LOAD through S_DONE
//    frame_done        out  1-cycle pulse in S_DONE
//    cmd_dropped       out  1-cycle pulse when a request is discarded
//  Revision    : 1.0  initial release
// ============================================================================
module tx_frame_controller #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          FLAG_WIDTH  = 2,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  display_cmd_pulse,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data_out,
  output logic                  tx_start_pulse,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  cmd_dropped
);

  localparam int c_nrb    = (DATA_WIDTH + 7) / 8;
  localparam int c_snap_w = c_nrb * 8;
`ifdef TX_FRAME_CHECKSUM_EN
  localparam int c_nbytes = 3 + c_nrb;
`else
  localparam int c_nbytes = 2 + c_nrb;
`endif
  localparam logic [2:0] c_last_idx  = 3'(c_nbytes - 1);
  localparam logic [2:0] c_flags_idx = 3'(c_nrb + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                r_state;
  logic [2:0]            r_byte_idx;
  logic                  r_pending;
  logic [c_snap_w-1:0]   r_snap;
  logic [FLAG_WIDTH-1:0] r_flags;
`ifdef TX_FRAME_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic [c_snap_w-1:0]   w_res_ext;
  logic [7:0]            w_flags_byte;
  logic [2:0]            w_sel_idx;
  logic [7:0]            w_byte;
  logic                  w_go;

  // w_byte is the byte that is launched on the next transition into S_SEND.
  // From S_LOAD that is always the header, which does not depend on the
  // snapshot being captured on the same edge.
  always_comb begin
    w_res_ext                   = '0;
    w_res_ext[DATA_WIDTH-1:0]   = alu_result;
    w_flags_byte                = '0;
    w_flags_byte[FLAG_WIDTH-1:0] = r_flags;
    w_sel_idx = (r_state == S_LOAD) ? 3'd0 : r_byte_idx + 3'd1;
    w_byte    = '0;
    if (w_sel_idx == 3'd0) begin
      w_byte = HEADER_BYTE;
    end else if (w_sel_idx == c_flags_idx) begin
      w_byte = w_flags_byte;
`ifdef TX_FRAME_CHECKSUM_EN
    end else if (w_sel_idx == 3'(c_nrb + 2)) begin
      w_byte = r_csum;
`endif
    end else begin
      for (int i = 0; i < c_nrb; i++) begin
        if (w_sel_idx == 3'(i + 1)) w_byte = r_snap[i*8 +: 8];
      end
    end
  end

  assign w_go = (r_state == S_IDLE) && (display_cmd_pulse || r_pending) && !tx_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_byte_idx     <= '0;
      r_pending      <= 1'b0;
      r_snap         <= '0;
      r_flags        <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
      r_csum         <= '0;
`endif
      tx_data_out    <= '0;
      tx_start_pulse <= 1'b0;
      frame_busy     <= 1'b0;
      frame_done     <= 1'b0;
      cmd_dropped    <= 1'b0;
    end else begin
      tx_start_pulse <= 1'b0;
      tx_data_out    <= '0;
      frame_done     <= 1'b0;
      cmd_dropped    <= 1'b0;

      // A request that cannot start right now is queued; only one fits.
      if (display_cmd_pulse && !w_go) begin
        if (r_pending) cmd_dropped <= 1'b1;
        else           r_pending   <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state    <= S_LOAD;
            frame_busy <= 1'b1;
            // If a pending request is served while a new pulse arrives,
            // the new pulse takes the pending slot.
            r_pending  <= r_pending & display_cmd_pulse;
          end
        end
        S_LOAD: begin
          r_snap         <= w_res_ext;
          r_flags        <= alu_flags;
          r_byte_idx     <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
          // Accumulator restarts here and already includes the header.
          r_csum         <= HEADER_BYTE;
`endif
          tx_start_pulse <= 1'b1;
          tx_data_out    <= w_byte;
          r_state        <= S_SEND;
        end
        S_SEND: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (r_byte_idx == c_last_idx) begin
              r_state    <= S_DONE;
              frame_done <= 1'b1;
            end else begin
              r_byte_idx     <= r_byte_idx + 3'd1;
              tx_start_pulse <= 1'b1;
              tx_data_out    <= w_byte;
`ifdef TX_FRAME_CHECKSUM_EN
              r_csum         <= r_csum ^ w_byte;
`endif
              r_state        <= S_SEND;
            end
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          frame_busy <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
